// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled CS/SCK/MOSI, MSB-first word deserialiser/serialiser with one-entry TX buffer.
// Optional sticky TX underrun flag when SPI_TARGET_UNDERRUN_EN is defined.
module spi_target #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = 8'hFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  selected_o,
`ifdef SPI_TARGET_UNDERRUN_EN
    output logic                  tx_underrun_o,
    input  logic                  tx_underrun_clr_i,
`endif
    input  logic                  spi_cs_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o
);

    localparam int unsigned CNT_W   = $clog2(DATA_WIDTH);
    localparam int unsigned FLUSH   = SYNC_STAGES + 1;
    localparam int unsigned FLUSH_W = $clog2(FLUSH + 1);

    typedef enum logic {
        IDLE     = 1'b0,
        SELECTED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    cs_prev_q, cs_prev_d;
    logic                    sck_prev_q, sck_prev_d;
    logic [FLUSH_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                    armed_q, armed_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
    logic                    tx_full_q, tx_full_d;
    logic                    reload_q, reload_d;

    logic                    cs_s, sck_s, mosi_s;
    logic                    cs_fall, cs_rise, sck_rise, sck_fall;
    logic                    flush_done;
    logic                    load;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   rx_word;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // The chain resets to "CS high"; only trust a falling edge once real samples
    // have flushed through and CS has been seen high, so a CS held low across
    // reset is not mistaken for a new selection.
    assign flush_done = (flush_cnt_q == FLUSH_W'(FLUSH));
    assign cs_fall    = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise    = ~cs_prev_q & cs_s;
    assign sck_rise   = ~sck_prev_q & sck_s;
    assign sck_fall   = sck_prev_q & ~sck_s;
    assign accept     = tx_valid_i & ~tx_full_q;
    assign rx_word    = {rx_shift_q, mosi_s};

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        cs_prev_d   = cs_s;
        sck_prev_d  = sck_s;
        flush_cnt_d = flush_done ? flush_cnt_q : flush_cnt_q + 1'b1;
        armed_d     = armed_q | (flush_done & cs_s & cs_prev_q);
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        reload_d   = reload_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SELECTED;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                    load      = 1'b1;
                end
            end
            SELECTED: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    reload_d   = 1'b0;
                    tx_shift_d = '0;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = rx_word[DATA_WIDTH-2:0];
                        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt_d  = '0;
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                            reload_d   = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    // A word boundary reloads on the falling edge so MISO carries the
                    // next MSB before the controller's next sampling edge.
                    if (sck_fall) begin
                        if (reload_q) begin
                            load     = 1'b1;
                            reload_d = 1'b0;
                        end else begin
                            tx_shift_d = tx_shift_q << 1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (tx_full_q) begin
                tx_shift_d = tx_buf_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = IDLE_WORD;
            end
        end
        // accept needs an empty buffer, so it never collides with a load that empties it
        if (accept) begin
            tx_buf_d  = tx_data_i;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
            flush_cnt_q <= '0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            reload_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sck_prev_q  <= sck_prev_d;
            flush_cnt_q <= flush_cnt_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            reload_q    <= reload_d;
        end
    end

`ifdef SPI_TARGET_UNDERRUN_EN
    logic underrun_q, underrun_d;
    logic underrun_set;

    assign underrun_set = load & ~tx_full_q;

    always_comb begin
        underrun_d = underrun_q;
        if (tx_underrun_clr_i) begin
            underrun_d = 1'b0;
        end
        if (underrun_set) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign tx_underrun_o = underrun_q;
`endif

    assign tx_ready_o    = ~tx_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign selected_o    = (state_q == SELECTED);
    assign spi_miso_oe_o = (state_q == SELECTED);
    assign spi_miso_o    = (state_q == SELECTED) ? tx_shift_q[DATA_WIDTH-1] : 1'b0;

endmodule
